pipelined_datapath: RTL and testbench

//  Parametrised successor of the single-cycle datapath: NREGS x DATA_W register file, 2-stage pipeline.

---
 rtl/pipelined_datapath.sv | 192 +++++++++++++++++++
 tb/tb_pipelined_datapath.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_datapath.sv
// pipelined_datapath: two-stage (RD, EX/WB) datapath with an NREGS x DATA_W
// register file, sign-extended immediate operand, ALU and {C,L,F,Z,N} flag register.
// Optional feature: define DP_BYPASS_EN to forward the stage-2 result into the
// stage-1 operand reads; without it stage 1 returns the pre-write register value.
module pipelined_datapath #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              valid_in,
    input  logic              writeEn,
    input  logic              selectImm,
    input  logic [ADDR_W-1:0] readRegA,
    input  logic [ADDR_W-1:0] readRegB,
    input  logic [ADDR_W-1:0] loadReg,
    input  logic [IMM_W-1:0]  Imm,
    input  logic [7:0]        op,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Z,
    output logic [4:0]        flags,
    output logic              valid_out
);

    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ADDC = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_MOV  = 4'hD;

    // Flag bit positions inside flags[4:0] = {C,L,F,Z,N}
    localparam int FC = 4;
    localparam int FL = 3;
    localparam int FF = 2;
    localparam int FZ = 1;
    localparam int FN = 0;

    // Register count widened by one bit so out-of-range indices compare cleanly
    localparam logic [ADDR_W:0] NREGS_L = NREGS[ADDR_W:0];

    logic [DATA_W-1:0] rf_r [NREGS];
    logic [3:0]        op_r;
    logic [ADDR_W-1:0] load_r;
    logic              we_r;
    logic              valid_r;

    logic [DATA_W-1:0] sext_s;
    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] opb_s;
    logic              byp_a_s;
    logic              byp_b_s;
    logic [DATA_W:0]   add_s;
    logic [DATA_W:0]   sub_s;
    logic              add_ovf_s;
    logic              sub_ovf_s;
    logic [DATA_W-1:0] res_s;
    logic [4:0]        nflags_s;
    logic              writes_s;
    logic              wr_en_s;
    logic              unused_s;

    // Upper opcode nibble carries no meaning for this datapath
    assign unused_s = ^op[7:4];

    // A completing instruction writes only for writing opcodes and in-range destinations
    assign wr_en_s = valid_r & we_r & writes_s & ({1'b0, load_r} < NREGS_L);

    // Stage-1 operand selection: immediate, optional forward, register file, or zero
    always_comb begin
        sext_s = {{(DATA_W - IMM_W){Imm[IMM_W-1]}}, Imm};
`ifdef DP_BYPASS_EN
        byp_a_s = wr_en_s && (readRegA == load_r);
        byp_b_s = wr_en_s && (readRegB == load_r);
`else
        byp_a_s = 1'b0;
        byp_b_s = 1'b0;
`endif
        if (byp_a_s) begin
            opa_s = res_s;
        end else if ({1'b0, readRegA} < NREGS_L) begin
            opa_s = rf_r[readRegA];
        end else begin
            opa_s = '0;
        end

        if (selectImm) begin
            opb_s = sext_s;
        end else if (byp_b_s) begin
            opb_s = res_s;
        end else if ({1'b0, readRegB} < NREGS_L) begin
            opb_s = rf_r[readRegB];
        end else begin
            opb_s = '0;
        end
    end

    // Stage-2 ALU: result, next flag value and whether the opcode writes back
    always_comb begin
        add_s     = {1'b0, A} + {1'b0, B} + {{DATA_W{1'b0}}, (op_r == OP_ADDC) ? flags[FC] : 1'b0};
        sub_s     = {1'b0, A} - {1'b0, B};
        add_ovf_s = (A[MSB] == B[MSB]) && (add_s[MSB] != A[MSB]);
        sub_ovf_s = (A[MSB] != B[MSB]) && (sub_s[MSB] != A[MSB]);
        res_s     = '0;
        nflags_s  = flags;
        writes_s  = 1'b0;
        case (op_r)
            OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                if (op_r == OP_AND) begin
                    res_s = A & B;
                end else if (op_r == OP_OR) begin
                    res_s = A | B;
                end else if (op_r == OP_XOR) begin
                    res_s = A ^ B;
                end else begin
                    res_s = B;
                end
                nflags_s[FZ] = (res_s == '0);
                nflags_s[FN] = res_s[MSB];
                writes_s     = 1'b1;
            end
            OP_ADD, OP_ADDC: begin
                res_s        = add_s[DATA_W-1:0];
                nflags_s[FC] = add_s[DATA_W];
                nflags_s[FF] = add_ovf_s;
                nflags_s[FZ] = (res_s == '0);
                nflags_s[FN] = res_s[MSB];
                writes_s     = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                res_s        = sub_s[DATA_W-1:0];
                nflags_s[FC] = sub_s[DATA_W];
                nflags_s[FL] = sub_s[DATA_W];
                nflags_s[FF] = sub_ovf_s;
                nflags_s[FZ] = (A == B);
                // Signed less-than is the difference sign corrected by overflow
                nflags_s[FN] = sub_s[MSB] ^ sub_ovf_s;
                writes_s     = (op_r == OP_SUB);
            end
            default: begin
                res_s    = '0;
                nflags_s = flags;
                writes_s = 1'b0;
            end
        endcase
    end

    // Pipeline registers, outputs and register-file write-back
    always_ff @(posedge CLK) begin
        if (CLR) begin
            A         <= '0;
            B         <= '0;
            op_r      <= 4'h0;
            load_r    <= '0;
            we_r      <= 1'b0;
            valid_r   <= 1'b0;
            Z         <= '0;
            flags     <= 5'b00000;
            valid_out <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= '0;
            end
        end else begin
            if (valid_in) begin
                A      <= opa_s;
                B      <= opb_s;
                op_r   <= op[3:0];
                load_r <= loadReg;
                we_r   <= writeEn;
            end
            valid_r <= valid_in;
            if (valid_r) begin
                Z         <= res_s;
                flags     <= nflags_s;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
            if (wr_en_s) begin
                rf_r[load_r] <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench for pipelined_datapath: directed cases plus randomized
// instruction streams compared against an instruction-level reference model.
// Follows DP_BYPASS_EN the same way the design does.
module tb_pipelined_datapath;

`ifdef DP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        CLR;
    logic        valid_in;
    logic        writeEn;
    logic        selectImm;
    logic [3:0]  readRegA;
    logic [3:0]  readRegB;
    logic [3:0]  loadReg;
    logic [7:0]  Imm;
    logic [7:0]  op;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Z;
    logic [4:0]  flags;
    logic        valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: architectural registers, flags and the instruction in flight
    logic [15:0] m_rf [16];
    logic [4:0]  m_fl;
    logic [15:0] m_a, m_b, m_z;
    logic        m_vo;
    logic        p_v, p_we;
    logic [3:0]  p_op, p_ld;

    pipelined_datapath dut (
        .CLK(CLK), .CLR(CLR), .valid_in(valid_in), .writeEn(writeEn),
        .selectImm(selectImm), .readRegA(readRegA), .readRegB(readRegB),
        .loadReg(loadReg), .Imm(Imm), .op(op),
        .A(A), .B(B), .Z(Z), .flags(flags), .valid_out(valid_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction semantics from the opcode table, using plain integer arithmetic
    function automatic void ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [3:0] o,
                                    input logic [4:0] fi, output logic [15:0] r,
                                    output logic [4:0] fo, output bit wr);
        int ua, ub, sa, sb, t, st, cin;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = 16'h0000;
        fo = fi;
        wr = 1'b1;
        case (o)
            4'h1, 4'h2, 4'h3, 4'hD: begin
                if (o == 4'h1)      r = a & b;
                else if (o == 4'h2) r = a | b;
                else if (o == 4'h3) r = a ^ b;
                else                r = b;
                fo = {fi[4], fi[3], fi[2], r == 16'h0000, r[15]};
            end
            4'h5, 4'h6: begin
                cin = (o == 4'h6) ? int'(fi[4]) : 0;
                t   = ua + ub + cin;
                st  = sa + sb + cin;
                r   = t[15:0];
                fo  = {t > 65535, fi[3], (st > 32767) || (st < -32768), r == 16'h0000, r[15]};
            end
            4'h9, 4'hB: begin
                t  = ua - ub;
                st = sa - sb;
                r  = t[15:0];
                fo = {ua < ub, ua < ub, (st > 32767) || (st < -32768), ua == ub, sa < sb};
                wr = (o == 4'h9);
            end
            default: begin
                r  = 16'h0000;
                fo = fi;
                wr = 1'b0;
            end
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        logic [15:0] res;
        logic [4:0]  nf;
        bit          wr;
        logic [15:0] old_rf [16];
        int          si;
        if (CLR) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
            m_fl = 5'b00000; m_a = 16'h0000; m_b = 16'h0000; m_z = 16'h0000;
            m_vo = 1'b0; p_v = 1'b0;
        end else begin
            old_rf = m_rf;
            if (p_v) begin
                ref_alu(m_a, m_b, p_op, m_fl, res, nf, wr);
                m_z  = res;
                m_fl = nf;
                m_vo = 1'b1;
                if (wr && p_we) m_rf[p_ld] = res;
            end else begin
                m_vo = 1'b0;
            end
            if (valid_in) begin
                si   = int'($signed(Imm));
                m_a  = BYP ? m_rf[readRegA] : old_rf[readRegA];
                m_b  = selectImm ? si[15:0] : (BYP ? m_rf[readRegB] : old_rf[readRegB]);
                p_op = op[3:0];
                p_ld = loadReg;
                p_we = writeEn;
            end
            p_v = valid_in;
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare every output with the model
    task automatic cycle(input bit clr, input bit vin, input bit we, input bit simm,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] ld,
                         input logic [7:0] imm, input logic [7:0] opc);
        CLR = clr; valid_in = vin; writeEn = we; selectImm = simm;
        readRegA = ra; readRegB = rb; loadReg = ld; Imm = imm; op = opc;
        @(posedge CLK);
        #1;
        model_edge();
        check_eq("valid_out", 32'(valid_out), 32'(m_vo));
        check_eq("Z", 32'(Z), 32'(m_z));
        check_eq("flags", 32'(flags), 32'(m_fl));
        check_eq("A", 32'(A), 32'(m_a));
        check_eq("B", 32'(B), 32'(m_b));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
    endtask

    // Read a register through operand A with an undefined (non-writing) opcode
    task automatic rd_chk(input logic [3:0] idx, input logic [15:0] exp, input string tag);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, idx, 4'h0, 4'h0, 8'h00, 8'h00);
        check_eq(tag, 32'(A), 32'(exp));
    endtask

    task automatic rand_cycles(input int n);
        logic [3:0] ops [9];
        logic [7:0] opc;
        ops = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD, 4'h0};
        for (int i = 0; i < n; i++) begin
            opc = 8'($urandom);
            if ($urandom_range(0, 7) != 0) opc[3:0] = ops[$urandom_range(0, 7)];
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), opc);
        end
    endtask

    initial begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);

        // Reset after random activity clears everything
        rand_cycles(200);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
        check_eq("rst_A", 32'(A), 32'h0);
        check_eq("rst_B", 32'(B), 32'h0);
        check_eq("rst_Z", 32'(Z), 32'h0);
        check_eq("rst_flags", 32'(flags), 32'h0);
        check_eq("rst_valid", 32'(valid_out), 32'h0);
        for (int i = 0; i < 16; i++) rd_chk(4'(i), 16'h0000, "rst_rf");
        idle(); idle();

        // MOV r1,#-3
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 8'hFD, 8'h0D);
        idle();
        check_eq("mov_Z", 32'(Z), 32'h0000FFFD);
        check_eq("mov_N", 32'(flags[0]), 32'h1);
        check_eq("mov_Zf", 32'(flags[1]), 32'h0);
        idle();
        rd_chk(4'h1, 16'hFFFD, "mov_r1");

        // r2=FFFF, r3=0001, ADD r7=r2+r3 then back-to-back ADDC r4=r0+0
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h2, 8'hFF, 8'h0D);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h3, 8'h01, 8'h0D);
        idle(); idle();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3, 4'h7, 8'h00, 8'h05);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h4, 8'h00, 8'h06);
        check_eq("add_Z", 32'(Z), 32'h0);
        check_eq("add_C", 32'(flags[4]), 32'h1);
        check_eq("add_Zf", 32'(flags[1]), 32'h1);
        idle();
        check_eq("addc_Z", 32'(Z), 32'h1);
        idle();

        // Build r9=8000 by doubling, r5=r9-1=7FFF, then CMP r5,#-1
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h9, 8'h40, 8'h0D);
        idle();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 4'h9, 4'h9, 8'h00, 8'h05);
            idle();
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 4'h0, 4'h5, 8'h01, 8'h09);
        idle(); idle();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'h0, 4'h5, 8'hFF, 8'h0B);
        idle();
        check_eq("cmp_C", 32'(flags[4]), 32'h1);
        check_eq("cmp_L", 32'(flags[3]), 32'h1);
        check_eq("cmp_Zf", 32'(flags[1]), 32'h0);
        check_eq("cmp_N", 32'(flags[0]), 32'h0);
        idle();
        rd_chk(4'h5, 16'h7FFF, "cmp_r5");
        idle();

        // Consecutive MOV r6,#5 ; ADD r6,r6,r6
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h6, 8'h05, 8'h0D);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 4'h6, 4'h6, 8'h00, 8'h05);
        idle(); idle();
        rd_chk(4'h6, BYP ? 16'h000A : 16'h0000, "raw_r6");
        idle();

        // CLR while an ADD occupies stage 2
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'hA, 8'h07, 8'h0D);
        idle(); idle();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 4'h0, 4'hA, 8'h01, 8'h05);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00);
        check_eq("clr_valid", 32'(valid_out), 32'h0);
        idle();
        check_eq("clr_valid2", 32'(valid_out), 32'h0);
        rd_chk(4'hA, 16'h0000, "clr_r10");

        rand_cycles(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
